imm_unit: RTL and testbench

//  RISC-V RV32I immediate generator in the decode stage.
//  - Input: instruction bits [31:7] and an immediate-format select.
//  - Output: the sign-/zero-extended 32-bit immediate, registered.
//  - Feeds the ALU B-operand mux and the branch/jump target adder.

---
 rtl/imm_unit.sv | 52 +++++
 tb/tb_imm_unit.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/imm_unit.sv
// imm_unit: registered RV32I immediate generator (I/S/B/U/J formats).
// Define IMM_ZIMM_EN to decode immsrc=101 as the CSR zimm; otherwise it is reserved.
module imm_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [24:0]     imm,
    input  logic [2:0]      immsrc,
    output logic [XLEN-1:0] immext,
    output logic            out_valid,
    output logic            illegal
);
    logic [XLEN-1:0] immext_q, immext_d, dec;
    logic            out_valid_q, out_valid_d, illegal_q, illegal_d, rsvd;
    logic            s;
    assign s = imm[24];
`ifdef IMM_ZIMM_EN
    assign rsvd = immsrc[2] & immsrc[1];
`else
    assign rsvd = immsrc[2] & (immsrc[1] | immsrc[0]);
`endif
    always_comb begin
        dec = immsrc == 3'b000 ? {{20{s}}, imm[24:13]} :
              immsrc == 3'b001 ? {{20{s}}, imm[24:18], imm[4:0]} :
              immsrc == 3'b010 ? {{19{s}}, imm[24], imm[0], imm[23:18], imm[4:1], 1'b0} :
              immsrc == 3'b011 ? {imm[24:5], 12'h000} :
              immsrc == 3'b100 ? {{11{s}}, imm[24], imm[12:5], imm[13], imm[23:14], 1'b0} :
`ifdef IMM_ZIMM_EN
              immsrc == 3'b101 ? {27'b0, imm[12:8]} :
`endif
              '0;
        immext_d    = in_valid ? dec : immext_q;
        illegal_d   = in_valid ? rsvd : illegal_q;
        out_valid_d = in_valid;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            immext_q    <= '0;
            out_valid_q <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            immext_q    <= immext_d;
            out_valid_q <= out_valid_d;
            illegal_q   <= illegal_d;
        end
    end
    assign immext    = immext_q;
    assign out_valid = out_valid_q;
    assign illegal   = illegal_q;
endmodule

// File: tb/tb_imm_unit.sv
// tb_imm_unit: directed and random checks of imm_unit against an instruction-field model.
module tb_imm_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [24:0] imm = '0;
    logic [2:0]  immsrc = '0;
    logic [31:0] immext;
    logic        out_valid, illegal;
    int checks = 0;
    int failures = 0;
    logic [31:0] exp_imm = '0;
    logic        exp_vld = 1'b0, exp_ill = 1'b0;

    imm_unit dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .imm(imm), .immsrc(immsrc),
        .immext(immext), .out_valid(out_valid), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // Model works on the full 32-bit instruction word using RISC-V field positions.
    task automatic ref_imm(input logic [24:0] im, input logic [2:0] src,
                           output logic [31:0] v, output logic ill);
        logic [31:0] instr;
        logic signed [11:0] i12;
        logic signed [12:0] b13;
        logic signed [20:0] j21;
        instr = {im, 7'b0};
        i12 = instr[31:20];
        b13 = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        j21 = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
        ill = 1'b0;
        case (src)
            3'd0: v = 32'(int'(i12));
            3'd1: begin i12 = {instr[31:25], instr[11:7]}; v = 32'(int'(i12)); end
            3'd2: v = 32'(int'(b13));
            3'd3: v = instr & 32'hFFFF_F000;
            3'd4: v = 32'(int'(j21));
`ifdef IMM_ZIMM_EN
            3'd5: v = 32'(instr[19:15]);
`endif
            default: begin v = 32'd0; ill = 1'b1; end
        endcase
    endtask

    task automatic step(input logic r, input logic v, input logic [2:0] src,
                        input logic [24:0] im, input string tag);
        logic [31:0] e;
        logic        il;
        rst = r; in_valid = v; immsrc = src; imm = im;
        @(posedge clk);
        #1;
        ref_imm(im, src, e, il);
        if (r) begin
            exp_imm = '0; exp_vld = 1'b0; exp_ill = 1'b0;
        end else if (v) begin
            exp_imm = e; exp_vld = 1'b1; exp_ill = il;
        end else
            exp_vld = 1'b0;
        checks++;
        assert (immext === exp_imm) else begin
            failures++;
            $error("FAIL %s immext got=%h exp=%h", tag, immext, exp_imm);
        end
        checks++;
        assert (out_valid === exp_vld) else begin
            failures++;
            $error("FAIL %s out_valid got=%b exp=%b", tag, out_valid, exp_vld);
        end
        checks++;
        assert (illegal === exp_ill) else begin
            failures++;
            $error("FAIL %s illegal got=%b exp=%b", tag, illegal, exp_ill);
        end
    endtask

    initial begin
        step(1, 0, 3'd0, 25'h0, "reset0");
        step(1, 1, 3'd0, 25'h1FFE001, "reset1");
        step(0, 1, 3'd0, 25'h1FFE001, "I_addi");
        checks++;
        assert (immext === 32'hFFFF_FFFF) else begin
            failures++;
            $error("FAIL I_const got=%h exp=%h", immext, 32'hFFFF_FFFF);
        end
        step(0, 1, 3'd1, 25'h1FCA25C, "S_sw");
        checks++;
        assert (immext === 32'hFFFF_FFFC) else begin
            failures++;
            $error("FAIL S_const got=%h exp=%h", immext, 32'hFFFF_FFFC);
        end
        step(0, 1, 3'd2, 25'h0000001, "B_bit7");
        checks++;
        assert (immext === 32'h0000_0800) else begin
            failures++;
            $error("FAIL B_const got=%h exp=%h", immext, 32'h0000_0800);
        end
        step(0, 1, 3'd0, 25'h0000001, "I_bit7");
        step(0, 1, 3'd1, 25'h0000001, "S_bit7");
        step(0, 1, 3'd3, 25'h0000001, "U_bit7");
        step(0, 1, 3'd3, 25'h02468A0, "U_lui");
        checks++;
        assert (immext === 32'h1234_5000) else begin
            failures++;
            $error("FAIL U_const got=%h exp=%h", immext, 32'h1234_5000);
        end
        step(0, 1, 3'd4, 25'h1000000, "J_neg");
        checks++;
        assert (immext === 32'hFFF0_0000) else begin
            failures++;
            $error("FAIL J_const got=%h exp=%h", immext, 32'hFFF0_0000);
        end
        step(0, 1, 3'd0, 25'h0ABCDEF, "b2b_I");
        step(0, 1, 3'd3, 25'h1234567, "b2b_U");
        step(0, 0, 3'd2, 25'h1FFFFFF, "hold1");
        step(0, 0, 3'd6, 25'h0000000, "hold2");
        step(0, 1, 3'd6, 25'h1FFFFFF, "rsvd110");
        step(0, 1, 3'd7, 25'h1FFFFFF, "rsvd111");
        step(0, 0, 3'd0, 25'h0, "hold_ill");
        step(0, 1, 3'd5, 25'h0001F00, "zimm");
`ifdef IMM_ZIMM_EN
        checks++;
        assert (immext === 32'h0000_001F && illegal === 1'b0) else begin
            failures++;
            $error("FAIL zimm_const got=%h/%b exp=%h/0", immext, illegal, 32'h1F);
        end
`else
        checks++;
        assert (immext === 32'h0 && illegal === 1'b1) else begin
            failures++;
            $error("FAIL zimm_rsvd got=%h/%b exp=0/1", immext, illegal);
        end
`endif
        step(0, 1, 3'd4, 25'h1FFFFFF, "pre_rst");
        step(1, 1, 3'd4, 25'h1FFFFFF, "mid_rst");
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 31) == 0, $urandom_range(0, 3) != 0,
                 3'($urandom_range(0, 7)), 25'($urandom), "rand");
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
